// File: rtl/twiddle_mul.sv
// Twiddle-factor multiplier following the radix-2 SDF butterfly: SUM samples pass at W^0,
// DIFF samples are rotated by W_N^k; 3-stage pipeline with round-half-up and saturation.
module twiddle_mul #(
  parameter int IN_W     = 13,
  parameter int TW_W     = 10,
  parameter int OUT_W    = 14,
  parameter int NUM_PAIR = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic                    sync,
  input  logic signed [IN_W-1:0]  bfly_out_re,
  input  logic signed [IN_W-1:0]  bfly_out_im,
  output logic signed [OUT_W-1:0] tw_out_re,
  output logic signed [OUT_W-1:0] tw_out_im,
  output logic                    tw_out_valid,
  output logic                    group_done
);

  localparam int  KW     = $clog2(NUM_PAIR);
  localparam int  PW     = IN_W + TW_W;
  localparam int  SW     = PW + 1;
  localparam int  ONE    = 1 << (TW_W - 2);
  localparam int  HALF_I = 1 << (TW_W - 3);
  localparam real PI     = 3.14159265358979323846;

  localparam logic signed [SW:0] MAXV = (SW+1)'((1 <<< (OUT_W - 1)) - 1);
  localparam logic signed [SW:0] MINV = (SW+1)'(-(1 <<< (OUT_W - 1)));

  typedef enum logic {SUM_PH, DIFF_PH} phase_t;

  phase_t          phase, phase_nxt;
  logic [KW-1:0]   k, k_nxt;
  logic signed [TW_W-1:0] c_sel, d_sel;
  logic            last_sel;

  logic signed [TW_W-1:0] cos_rom [NUM_PAIR];
  logic signed [TW_W-1:0] sin_rom [NUM_PAIR];

  // Constant coefficient table: c = cos, d = -sin, rounded to nearest at elaboration.
  for (genvar gk = 0; gk < NUM_PAIR; gk++) begin : g_rom
    localparam int C = int'($cos(PI * gk / NUM_PAIR) * ONE);
    localparam int D = int'(-$sin(PI * gk / NUM_PAIR) * ONE);
    assign cos_rom[gk] = TW_W'(C);
    assign sin_rom[gk] = TW_W'(D);
  end

  function automatic logic signed [OUT_W-1:0] rnd_sat(input logic signed [SW-1:0] x);
    logic signed [SW:0] t;
    t = (SW+1)'(x) + (SW+1)'(HALF_I);
    t = t >>> (TW_W - 2);
    if (t > MAXV)      rnd_sat = OUT_W'(MAXV);
    else if (t < MINV) rnd_sat = OUT_W'(MINV);
    else               rnd_sat = OUT_W'(t);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= SUM_PH;
      k     <= '0;
    end else begin
      phase <= phase_nxt;
      k     <= k_nxt;
    end
  end

  always_comb begin
    phase_nxt = phase;
    k_nxt     = k;
    if (in_valid) begin
      if (sync) begin
        phase_nxt = SUM_PH;
        k_nxt     = KW'(1);
      end else if (k == KW'(NUM_PAIR - 1)) begin
        phase_nxt = (phase == SUM_PH) ? DIFF_PH : SUM_PH;
        k_nxt     = '0;
      end else begin
        k_nxt = k + KW'(1);
      end
    end
  end

  // A sync sample is always SUM index 0, whatever the running state says.
  always_comb begin
    c_sel    = TW_W'(ONE);
    d_sel    = '0;
    last_sel = 1'b0;
    if (phase == DIFF_PH && !sync) begin
      c_sel    = cos_rom[k];
      d_sel    = sin_rom[k];
      last_sel = (k == KW'(NUM_PAIR - 1));
    end
  end

  // S1: operands and coefficients
  logic                   vld_p0, last_p0;
  logic signed [IN_W-1:0] a_p0, b_p0;
  logic signed [TW_W-1:0] c_p0, d_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0  <= 1'b0;
      last_p0 <= 1'b0;
    end else begin
      vld_p0  <= in_valid;
      last_p0 <= in_valid & last_sel;
    end
  end

  always_ff @(posedge clk) begin
    a_p0 <= bfly_out_re;
    b_p0 <= bfly_out_im;
    c_p0 <= c_sel;
    d_p0 <= d_sel;
  end

  // S2: partial products
  logic                 vld_p1, last_p1;
  logic signed [PW-1:0] ac_p1, bd_p1, ad_p1, bc_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end else begin
      vld_p1  <= vld_p0;
      last_p1 <= last_p0;
    end
  end

  always_ff @(posedge clk) begin
    ac_p1 <= PW'(a_p0) * PW'(c_p0);
    bd_p1 <= PW'(b_p0) * PW'(d_p0);
    ad_p1 <= PW'(a_p0) * PW'(d_p0);
    bc_p1 <= PW'(b_p0) * PW'(c_p0);
  end

  // S3: combine, round and saturate
  logic                    vld_p2, last_p2;
  logic signed [OUT_W-1:0] re_p2, im_p2;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2  <= 1'b0;
      last_p2 <= 1'b0;
    end else begin
      vld_p2  <= vld_p1;
      last_p2 <= last_p1;
    end
  end

  always_ff @(posedge clk) begin
    re_p2 <= rnd_sat(SW'(ac_p1) - SW'(bd_p1));
    im_p2 <= rnd_sat(SW'(ad_p1) + SW'(bc_p1));
  end

  assign tw_out_valid = vld_p2;
  assign tw_out_re    = vld_p2 ? re_p2 : '0;
  assign tw_out_im    = vld_p2 ? im_p2 : '0;
  assign group_done   = vld_p2 & last_p2;

endmodule

// File: tb/tb_twiddle_mul.sv
// Bench for twiddle_mul: directed steps plus random traffic checked against a
// cosine/sine reference model; a second instance with OUT_W = 12 covers saturation.
module tb_twiddle_mul;

  localparam int IN_W  = 13;
  localparam int TW_W  = 10;
  localparam int OUT_W = 14;
  localparam int NP    = 8;
  localparam int MAXC  = 2048;
  localparam real PI   = 3.14159265358979323846;
  localparam real SCALE = 256.0;

  logic clk = 1'b0;
  logic rst, in_valid, sync;
  logic signed [IN_W-1:0]  re_in, im_in;
  logic signed [OUT_W-1:0] o_re, o_im;
  logic                    o_vld, o_done;
  logic signed [11:0]      s_re, s_im;
  logic                    s_vld, s_done;

  always #5 clk = ~clk;

  twiddle_mul #(.IN_W(IN_W), .TW_W(TW_W), .OUT_W(OUT_W), .NUM_PAIR(NP)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .sync(sync),
    .bfly_out_re(re_in), .bfly_out_im(im_in),
    .tw_out_re(o_re), .tw_out_im(o_im), .tw_out_valid(o_vld), .group_done(o_done)
  );

  twiddle_mul #(.IN_W(IN_W), .TW_W(TW_W), .OUT_W(12), .NUM_PAIR(NP)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .sync(sync),
    .bfly_out_re(re_in), .bfly_out_im(im_in),
    .tw_out_re(s_re), .tw_out_im(s_im), .tw_out_valid(s_vld), .group_done(s_done)
  );

  int exp_re [MAXC];
  int exp_im [MAXC];
  int exp_sre[MAXC];
  int exp_sim[MAXC];
  int exp_vld[MAXC];
  int exp_dn [MAXC];

  int cyc = 0;
  int m_phase = 0;
  int m_k = 0;
  int n_chk = 0;
  int n_fail = 0;
  int gd_cnt = 0;
  int vld_cnt = 0;

  function automatic int rnd(real x);
    if (x >= 0.0) return int'($floor(x + 0.5));
    else          return -int'($floor(-x + 0.5));
  endfunction

  // Round half up after scaling by 1.0 = 256, then clip to the output range.
  function automatic int scale_sat(longint v, int ow);
    real r;
    int  lim;
    r   = $floor(real'(v) / SCALE + 0.5);
    lim = 1 << (ow - 1);
    if (r > real'(lim - 1)) return lim - 1;
    if (r < real'(-lim))    return -lim;
    return int'(r);
  endfunction

  task automatic chk(string tag, int got, int expv);
    n_chk++;
    assert (got === expv) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d got %0d expected %0d", tag, cyc, got, expv);
    end
  endtask

  task automatic step(bit v, bit s, int re, int im, bit r);
    int  ph, kk, c, d;
    longint pr, pi_;
    rst = r; in_valid = v; sync = s;
    re_in = IN_W'(re); im_in = IN_W'(im);
    @(posedge clk);
    cyc++;
    if (r) begin
      for (int j = 0; j < 3; j++) begin
        exp_vld[cyc+j] = 0; exp_dn[cyc+j] = 0;
        exp_re[cyc+j] = 0;  exp_im[cyc+j] = 0;
        exp_sre[cyc+j] = 0; exp_sim[cyc+j] = 0;
      end
      m_phase = 0; m_k = 0;
    end else if (v) begin
      if (s) begin
        ph = 0; kk = 0; m_phase = 0; m_k = 1;
      end else begin
        ph = m_phase; kk = m_k;
        m_k++;
        if (m_k == NP) begin m_k = 0; m_phase = 1 - m_phase; end
      end
      if (ph == 0) begin
        c = 256; d = 0;
      end else begin
        c = rnd($cos(PI * kk / NP) * SCALE);
        d = rnd(-$sin(PI * kk / NP) * SCALE);
      end
      pr  = longint'(re) * c - longint'(im) * d;
      pi_ = longint'(re) * d + longint'(im) * c;
      exp_vld[cyc+2] = 1;
      exp_re [cyc+2] = scale_sat(pr, OUT_W);
      exp_im [cyc+2] = scale_sat(pi_, OUT_W);
      exp_sre[cyc+2] = scale_sat(pr, 12);
      exp_sim[cyc+2] = scale_sat(pi_, 12);
      exp_dn [cyc+2] = (ph == 1 && kk == NP - 1) ? 1 : 0;
    end
    #1;
    chk("valid", int'(o_vld), exp_vld[cyc]);
    chk("re", int'(o_re), exp_re[cyc]);
    chk("im", int'(o_im), exp_im[cyc]);
    chk("done", int'(o_done), exp_dn[cyc]);
    chk("sat_valid", int'(s_vld), exp_vld[cyc]);
    chk("sat_re", int'(s_re), exp_sre[cyc]);
    chk("sat_im", int'(s_im), exp_sim[cyc]);
    chk("sat_done", int'(s_done), exp_dn[cyc]);
    gd_cnt  += int'(o_done);
    vld_cnt += int'(o_vld);
  endtask

  function automatic int rv();
    return int'($urandom_range(0, 8191)) - 4096;
  endfunction

  int gd0, v0;

  initial begin
    rst = 1'b1; in_valid = 1'b0; sync = 1'b0; re_in = '0; im_in = '0;
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("reset_re", int'(o_re), 0);
    chk("reset_valid", int'(o_vld), 0);

    // T1 pass-through
    gd0 = gd_cnt; v0 = vld_cnt;
    for (int i = 0; i < NP; i++) step(1, i == 0, i * 100, -i * 50, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
    chk("t1_vld_cnt", vld_cnt - v0, NP);
    chk("t1_no_done", gd_cnt - gd0, 0);

    // T2 DIFF k=2 and k=4 (state is now DIFF, k=0)
    step(1, 0, rv(), rv(), 0);
    step(1, 0, rv(), rv(), 0);
    step(1, 0, 100, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("t2_k2_re", int'(o_re), 71);
    chk("t2_k2_im", int'(o_im), -71);
    step(1, 0, rv(), rv(), 0);
    step(1, 0, 100, 50, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("t2_k4_re", int'(o_re), 50);
    chk("t2_k4_im", int'(o_im), -100);
    for (int i = 5; i < NP; i++) step(1, 0, rv(), rv(), 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);

    // T3 two full groups back to back
    gd0 = gd_cnt;
    for (int i = 0; i < 4 * NP; i++) step(1, i == 0, rv(), rv(), 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
    chk("t3_done_cnt", gd_cnt - gd0, 2);

    // T4 gaps 1-0-0-1 across a group
    gd0 = gd_cnt;
    for (int i = 0; i < 2 * NP; i++) begin
      step(1, i == 0, rv(), rv(), 0);
      if (i % 2 == 0) begin
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
      end
    end
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
    chk("t4_done_cnt", gd_cnt - gd0, 1);

    // T5 saturation on the narrow-output instance
    step(1, 1, 4095, -4096, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("t5_sat_re", int'(s_re), 2047);
    chk("t5_sat_im", int'(s_im), -2048);
    chk("t5_wide_re", int'(o_re), 4095);
    chk("t5_wide_im", int'(o_im), -4096);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);

    // T6 reset at DIFF k=3 with two samples in flight
    for (int i = 0; i < NP + 3; i++) step(1, i == 0, rv(), rv(), 0);
    step(1, 0, rv(), rv(), 1);
    chk("t6_vld_after_rst", int'(o_vld), 0);
    chk("t6_re_after_rst", int'(o_re), 0);
    step(1, 0, 300, -200, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("t6_sum_re", int'(o_re), 300);
    chk("t6_sum_im", int'(o_im), -200);
    chk("t6_sum_valid", int'(o_vld), 1);

    // Random traffic with occasional sync and reset
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, rv(), rv(),
           $urandom_range(0, 99) == 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
